uart_tx_fifo: RTL and testbench

- UART transmitter for the photo-frame design; the transmit-side counterpart to the existing UART receive path in top.
- Accepts bytes from fabric logic through a one-cycle send strobe (i_scd_flag / i_scd_data) and queues them in an internal FIFO.
- Serialises queued bytes onto o_tx as 8N1 frames at BAUD_RATE, with back-to-back frames when the FIFO holds data.
- Lives in top beside the receiver; both run off i_clk_sys, so TX can loop back to RX.

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a byte FIFO in front of the shifter.
// Bytes written via a one-cycle strobe are queued and sent back-to-back.
module uart_tx_fifo #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int FIFO_AW   = 4
) (
    input  logic               i_clk_sys,
    input  logic               i_rst_n,
    input  logic               i_scd_flag,
    input  logic [7:0]         i_scd_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done,
    output logic [FIFO_AW:0]   o_fifo_cnt,
    output logic               o_fifo_full,
    output logic               o_fifo_empty,
    output logic               o_overflow
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int DEPTH      = 2 ** FIFO_AW;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0]      LAST = CW'(BIT_CYCLES - 1);
    localparam logic [FIFO_AW:0]   FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        cnt_bit;
    logic [2:0]           idx;
    logic [7:0]           shift;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     cnt_nx;
    logic                 bit_end;
    logic                 has_data;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 tx_nx;
    logic                 done_nx;

    assign bit_end  = (cnt_bit == LAST);
    assign has_data = (o_fifo_cnt != '0);
    assign pop      = has_data &&
                      (state == IDLE || (state == STOP && bit_end));
    assign push     = i_scd_flag && (!o_fifo_full || pop);
    assign drop     = i_scd_flag && o_fifo_full && !pop;
    assign cnt_nx   = o_fifo_cnt + (FIFO_AW + 1)'(push)
                                 - (FIFO_AW + 1)'(pop);

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (has_data) state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && idx == 3'd7) state_nx = STOP;
            STOP:    if (bit_end) state_nx = has_data ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_nx   = o_tx;
        done_nx = 1'b0;
        unique case (state)
            IDLE:    if (has_data) tx_nx = 1'b0;
            START:   if (bit_end) tx_nx = shift[0];
            DATA:    if (bit_end) tx_nx = (idx == 3'd7) ? 1'b1 : shift[0];
            STOP: begin
                if (bit_end) begin
                    done_nx = 1'b1;
                    tx_nx   = has_data ? 1'b0 : 1'b1;
                end
            end
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            o_tx_done <= 1'b0;
            cnt_bit   <= '0;
            idx       <= '0;
            shift     <= '0;
        end else begin
            o_tx      <= tx_nx;
            o_busy    <= (state_nx != IDLE);
            o_tx_done <= done_nx;
            if (state == IDLE || bit_end) cnt_bit <= '0;
            else cnt_bit <= cnt_bit + CW'(1);
            if (state == START && bit_end) idx <= '0;
            else if (state == DATA && bit_end) idx <= idx + 3'd1;
            // shift[0] always holds the next data bit to drive
            if (pop) shift <= mem[rd_ptr];
            else if ((state == START || state == DATA) && bit_end)
                shift <= {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (push) mem[wr_ptr] <= i_scd_data;
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_cnt   <= '0;
            o_fifo_full  <= 1'b0;
            o_fifo_empty <= 1'b1;
            o_overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            o_fifo_cnt   <= cnt_nx;
            o_fifo_full  <= (cnt_nx == FULL);
            o_fifo_empty <= (cnt_nx == '0);
            o_overflow   <= o_overflow | drop;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default-rate frame plus a fast
// instance (4 cycles/bit) for back-to-back, overflow and reset cases.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_d, flag_f;
    logic [7:0] data_d, data_f;
    logic       tx_d, busy_d, done_d, full_d, empty_d, ovf_d;
    logic       tx_f, busy_f, done_f, full_f, empty_f, ovf_f;
    logic [4:0] cnt_d, cnt_f;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] q [0:31];
    int         nfr;

    always #5 clk = ~clk;

    uart_tx_fifo dut_d (
        .i_clk_sys(clk), .i_rst_n(rst_n),
        .i_scd_flag(flag_d), .i_scd_data(data_d),
        .o_tx(tx_d), .o_busy(busy_d), .o_tx_done(done_d),
        .o_fifo_cnt(cnt_d), .o_fifo_full(full_d),
        .o_fifo_empty(empty_d), .o_overflow(ovf_d)
    );

    uart_tx_fifo #(.CLK_FREQ(4), .BAUD_RATE(1), .FIFO_AW(4)) dut_f (
        .i_clk_sys(clk), .i_rst_n(rst_n),
        .i_scd_flag(flag_f), .i_scd_data(data_f),
        .o_tx(tx_f), .o_busy(busy_f), .o_tx_done(done_f),
        .o_fifo_cnt(cnt_f), .o_fifo_full(full_f),
        .o_fifo_empty(empty_f), .o_overflow(ovf_f)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h",
                   tag, t, obs, exp);
        end
    endtask

    // Ideal line level t cycles after the first start-bit edge
    function automatic logic exp_tx(input int t, input int bc);
        int f;
        int b;
        f = t / (10 * bc);
        b = (t % (10 * bc)) / bc;
        if (f >= nfr) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return q[f][b-1];
    endfunction

    task automatic frames(input int t0, input int t1,
                          input int bc, input bit fast);
        for (int t = t0; t <= t1; t++) begin
            logic tx, bz, dn;
            tx = fast ? tx_f : tx_d;
            bz = fast ? busy_f : busy_d;
            dn = fast ? done_f : done_d;
            chk("tx", t, 32'(tx), 32'(exp_tx(t, bc)));
            chk("done", t, 32'(dn),
                32'(t > 0 && t % (10 * bc) == 0 && t / (10 * bc) <= nfr));
            chk("busy", t, 32'(bz), 32'(t < 10 * bc * nfr));
            if (t < t1) tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        flag_d = 1'b0;
        flag_f = 1'b0;
        data_d = 8'h00;
        data_f = 8'h00;
        nfr    = 0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_tx", -1, 32'(tx_d), 32'd1);
        chk("rst_busy", -1, 32'(busy_d), 32'd0);
        chk("rst_done", -1, 32'(done_d), 32'd0);
        chk("rst_cnt", -1, 32'(cnt_d), 32'd0);
        chk("rst_empty", -1, 32'(empty_d), 32'd1);
        chk("rst_full", -1, 32'(full_d), 32'd0);
        chk("rst_ovf", -1, 32'(ovf_d), 32'd0);
        chk("rst_tx_f", -1, 32'(tx_f), 32'd1);
        chk("rst_empty_f", -1, 32'(empty_f), 32'd1);
        for (int i = 0; i < 100; i++) tick();
        chk("idle_tx", -1, 32'(tx_d), 32'd1);
        chk("idle_busy", -1, 32'(busy_d), 32'd0);
        chk("idle_empty", -1, 32'(empty_d), 32'd1);
        chk("idle_cnt", -1, 32'(cnt_d), 32'd0);
        chk("idle_ovf", -1, 32'(ovf_d), 32'd0);

        // Single 0x5A frame at the default baud rate
        q[0] = 8'h5A;
        nfr  = 1;
        flag_d = 1'b1;
        data_d = 8'h5A;
        tick();
        flag_d = 1'b0;
        chk("wr_tx", -1, 32'(tx_d), 32'd1);
        chk("wr_cnt", -1, 32'(cnt_d), 32'd1);
        chk("wr_busy", -1, 32'(busy_d), 32'd0);
        tick();
        frames(0, 52085, 5208, 1'b0);
        chk("d_cnt", -1, 32'(cnt_d), 32'd0);
        chk("d_empty", -1, 32'(empty_d), 32'd1);

        // Three back-to-back frames, 4 cycles per bit
        q[0] = 8'h01;
        q[1] = 8'h80;
        q[2] = 8'hFF;
        nfr  = 3;
        flag_f = 1'b1;
        data_f = 8'h01;
        tick();
        chk("b2b_cnt0", -1, 32'(cnt_f), 32'd1);
        data_f = 8'h80;
        tick();
        chk("b2b_cnt1", 0, 32'(cnt_f), 32'd1);
        chk("b2b_fall", 0, 32'(tx_f), 32'd0);
        data_f = 8'hFF;
        tick();
        flag_f = 1'b0;
        chk("b2b_cnt2", 1, 32'(cnt_f), 32'd2);
        frames(1, 45, 4, 1'b1);
        chk("b2b_cnt45", 45, 32'(cnt_f), 32'd1);
        frames(45, 85, 4, 1'b1);
        chk("b2b_cnt85", 85, 32'(cnt_f), 32'd0);
        frames(85, 125, 4, 1'b1);
        chk("b2b_empty", -1, 32'(empty_f), 32'd1);

        // Level-held strobe for 18 cycles: fills FIFO, drops last byte
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        flag_f = 1'b1;
        for (int k = 0; k < 18; k++) begin
            data_f = 8'(k);
            tick();
            if (k == 16) begin
                chk("fill_cnt", -1, 32'(cnt_f), 32'd16);
                chk("fill_full", -1, 32'(full_f), 32'd1);
                chk("fill_ovf0", -1, 32'(ovf_f), 32'd0);
            end
            if (k == 17) begin
                chk("ovf_cnt", -1, 32'(cnt_f), 32'd16);
                chk("ovf_full", -1, 32'(full_f), 32'd1);
                chk("ovf_set", -1, 32'(ovf_f), 32'd1);
            end
        end
        flag_f = 1'b0;
        for (int i = 0; i < 17; i++) q[i] = 8'(i);
        nfr = 17;
        frames(16, 685, 4, 1'b1);
        chk("drain_cnt", -1, 32'(cnt_f), 32'd0);
        chk("drain_empty", -1, 32'(empty_f), 32'd1);
        chk("drain_full", -1, 32'(full_f), 32'd0);
        chk("ovf_sticky", -1, 32'(ovf_f), 32'd1);

        // Reset during data bit 3 with five bytes queued
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ovf_clr", -1, 32'(ovf_f), 32'd0);
        flag_f = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_f = 8'hA0 + 8'(k);
            tick();
        end
        flag_f = 1'b0;
        for (int i = 0; i < 6; i++) q[i] = 8'hA0 + 8'(i);
        nfr = 6;
        chk("q5_cnt", 4, 32'(cnt_f), 32'd5);
        frames(4, 17, 4, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abort_tx", -1, 32'(tx_f), 32'd1);
        chk("abort_cnt", -1, 32'(cnt_f), 32'd0);
        chk("abort_empty", -1, 32'(empty_f), 32'd1);
        chk("abort_busy", -1, 32'(busy_f), 32'd0);
        chk("abort_done", -1, 32'(done_f), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("post_tx", i, 32'(tx_f), 32'd1);
            chk("post_busy", i, 32'(busy_f), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
